// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM encoding and the instruction queue entry.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

    localparam int unsigned IMEM_BYTES_DEF = 128;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Shift-register instruction FIFO; entry 0 is the head so it leaves straight from flops.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head,
    output logic             head_valid
);

    fetch_entry_t     ent_q [DEPTH];
    fetch_entry_t     ent_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wr_idx;
    logic             valid_q, valid_d;
    logic             do_pop, do_push;

    always_comb begin
        ent_d   = ent_q;
        count_d = count_q;
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q < CNT_W'(DEPTH)) || do_pop);
        wr_idx  = count_q - CNT_W'(do_pop);
        if (flush) begin
            count_d = '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    ent_d[i] = ent_q[i+1];
                end
                ent_d[DEPTH-1] = '{instr: NOP_WORD, pc: '0};
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (do_push && (wr_idx == CNT_W'(i))) begin
                    ent_d[i] = push_data;
                end
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign count      = count_q;
    assign head       = ent_q[0];
    assign head_valid = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: accepts PC addresses, runs one req/ack imem read at a time,
// queues returned words for decode and drops work on redirect.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEF,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic [31:0]       pAddr,
    input  logic              pc_valid,
    output logic              fetch_ready,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned TMO_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned TMO_W   = (TMO_RAW > 4) ? TMO_RAW : 4;

    fetch_state_e      state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic              imem_req_q, imem_req_d;
    logic              fetch_err_q, fetch_err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
    logic              ready_c;
    logic              q_push;
    logic [CNT_W-1:0]  q_count;
    fetch_entry_t      q_head;
    logic              q_valid;

    // Next-state and datapath; a slot is reserved at accept so a push never overflows.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        imem_addr_d = imem_addr_q;
        imem_req_d  = imem_req_q;
        fetch_err_d = fetch_err_q;
        tmo_d       = tmo_q;
        tmo_inc     = tmo_q + TMO_W'(1);
        ready_c     = 1'b0;
        q_push      = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                ready_c = reset && !flush && (q_count < CNT_W'(DEPTH));
                if (pc_valid && ready_c) begin
                    addr_d      = pAddr;
                    imem_addr_d = (pAddr < 32'(IMEM_BYTES)) ? pAddr[ADDR_W+1:2] : '0;
                    imem_req_d  = 1'b1;
                    tmo_d       = '0;
                    state_d     = FETCH_REQ;
                end
            end
            FETCH_REQ, FETCH_DISCARD: begin
                if (imem_ack) begin
                    q_push     = (state_q == FETCH_REQ) && !flush;
                    imem_req_d = 1'b0;
                    state_d    = FETCH_IDLE;
                end else if (tmo_inc == TMO_W'(TIMEOUT)) begin
                    fetch_err_d = 1'b1;
                    imem_req_d  = 1'b0;
                    state_d     = FETCH_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                    if (flush) begin
                        state_d = FETCH_DISCARD;
                    end
                end
            end
            default: begin
                imem_req_d = 1'b0;
                state_d    = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH_IDLE;
            addr_q      <= '0;
            imem_addr_q <= '0;
            imem_req_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            imem_addr_q <= imem_addr_d;
            imem_req_q  <= imem_req_d;
            fetch_err_q <= fetch_err_d;
            tmo_q       <= tmo_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clkin      (clkin),
        .reset      (reset),
        .push       (q_push),
        .push_data  ('{instr: imem_rdata, pc: addr_q}),
        .pop        (instr_ready && q_valid),
        .flush      (flush),
        .count      (q_count),
        .head       (q_head),
        .head_valid (q_valid)
    );

    assign fetch_ready = ready_c;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign fetch_err   = fetch_err_q;
    assign instr       = q_head.instr;
    assign instr_pc    = q_head.pc;
    assign instr_valid = q_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level reference model with an imem responder,
// directed scenarios followed by randomized traffic.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH      = 2;
    localparam int unsigned IMEM_BYTES = 128;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned TIMEOUT    = 15;

    logic              clkin = 1'b0;
    logic              reset;
    logic [31:0]       pAddr;
    logic              pc_valid;
    logic              fetch_ready;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              fetch_err;

    instr_fetch_unit #(
        .DEPTH      (DEPTH),
        .IMEM_BYTES (IMEM_BYTES),
        .ADDR_W     (ADDR_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .pAddr       (pAddr),
        .pc_valid    (pc_valid),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err)
    );

    always #5 clkin = ~clkin;

    int n_tests = 0;
    int n_fail  = 0;

    // Instruction memory contents and responder state
    logic [31:0] mem [32];
    int          req_age   = 0;
    int          lat       = 0;
    int          fixed_lat = 0;
    bit          late_ack  = 1'b0;

    // Reference model: one outstanding fetch, expected queue of {word, pc}
    bit          m_out    = 1'b0;
    logic [31:0] m_pc     = '0;
    bit          m_killed = 1'b0;
    int          m_wait   = 0;
    bit          m_err    = 1'b0;
    logic [63:0] m_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] exp_waddr(input logic [31:0] a);
        logic [31:0] t;
        t = a;
        return (a < 32'(IMEM_BYTES)) ? t[ADDR_W+1:2] : '0;
    endfunction

    // One clock: respond to imem, check outputs against model, advance model across the edge.
    task automatic step();
        bit          exp_rdy;
        bit          n_out, n_killed, n_err, push;
        int          n_wait;
        logic [31:0] n_pc;
        logic [63:0] front;

        imem_ack   = 1'b0;
        imem_rdata = $urandom();
        if (late_ack) begin
            imem_ack = 1'b1;
        end else if (imem_req) begin
            if (req_age == 0)
                lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
            if (req_age == lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
            end
            req_age++;
        end else begin
            req_age = 0;
        end
        #1;

        exp_rdy = !flush && !m_out && (m_q.size() < DEPTH);
        check("fetch_ready", 32'(fetch_ready), 32'(exp_rdy));
        check("imem_req", 32'(imem_req), 32'(m_out));
        if (m_out) check("imem_addr", 32'(imem_addr), 32'(exp_waddr(m_pc)));
        check("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            front = m_q[0];
            check("instr", instr, front[63:32]);
            check("instr_pc", instr_pc, front[31:0]);
        end
        check("fetch_err", 32'(fetch_err), 32'(m_err));

        n_out = m_out; n_pc = m_pc; n_killed = m_killed; n_wait = m_wait; n_err = m_err;
        push = 1'b0;
        if (m_out) begin
            if (imem_ack) begin
                n_out = 1'b0;
                push  = !m_killed && !flush;
            end else if (m_wait + 1 == int'(TIMEOUT)) begin
                n_out = 1'b0;
                n_err = 1'b1;
            end else begin
                n_wait = m_wait + 1;
                if (flush) n_killed = 1'b1;
            end
        end else if (pc_valid && exp_rdy) begin
            n_out = 1'b1; n_pc = pAddr; n_killed = 1'b0; n_wait = 0;
        end

        @(posedge clkin);
        if (flush) begin
            m_q.delete();
        end else begin
            if (instr_ready && m_q.size() != 0) void'(m_q.pop_front());
            if (push) m_q.push_back({mem[exp_waddr(m_pc)], m_pc});
        end
        m_out = n_out; m_pc = n_pc; m_killed = n_killed; m_wait = n_wait; m_err = n_err;
        @(negedge clkin);
    endtask

    task automatic fetch(input logic [31:0] a);
        pAddr = a; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom();
        mem[0] = 32'h2001_0005;
        mem[2] = 32'hDEAD_BEEF;
        reset = 1'b0; pAddr = '0; pc_valid = 1'b0; flush = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        @(negedge clkin); @(negedge clkin);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_imem_addr", 32'(imem_addr), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'h0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'h0);
        reset = 1'b1;

        // Basic fetch with immediate ack
        fixed_lat = 0;
        fetch(32'h0);
        repeat (3) step();

        // Back-pressure: fill both slots, then pop one
        instr_ready = 1'b1; repeat (2) step();
        instr_ready = 1'b0;
        fetch(32'h0); step();
        fetch(32'h4); step();
        step();
        instr_ready = 1'b1; step();
        instr_ready = 1'b0; step();
        instr_ready = 1'b1; repeat (2) step();

        // Flush while waiting for a slow ack, then a clean fetch
        fixed_lat = 4;
        fetch(32'h8);
        repeat (2) step();
        flush = 1'b1; step();
        flush = 1'b0; repeat (3) step();
        fixed_lat = 0;
        fetch(32'h10); repeat (3) step();

        // Flush, ack and pop in the same cycle with one entry queued
        instr_ready = 1'b0;
        fetch(32'h0); step();
        fixed_lat = 1;
        fetch(32'h4); step();
        flush = 1'b1; instr_ready = 1'b1; step();
        flush = 1'b0; instr_ready = 1'b0; repeat (2) step();

        // Out-of-range address, then a request that never acks
        fixed_lat = 0; instr_ready = 1'b1;
        fetch(32'h80); repeat (3) step();
        fixed_lat = 99;
        fetch(32'hC);
        repeat (17) step();

        // Async reset in the middle of a request with a queued entry
        fixed_lat = 0; instr_ready = 1'b0;
        fetch(32'h18); step();
        fixed_lat = 99;
        fetch(32'h14); repeat (2) step();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_imem_req", 32'(imem_req), 32'h0);
        check("mid_rst_instr_valid", 32'(instr_valid), 32'h0);
        check("mid_rst_fetch_err", 32'(fetch_err), 32'h0);
        check("mid_rst_fetch_ready", 32'(fetch_ready), 32'h0);
        m_out = 1'b0; m_killed = 1'b0; m_wait = 0; m_err = 1'b0; m_q.delete(); req_age = 0;
        @(negedge clkin); @(negedge clkin);
        reset = 1'b1;
        late_ack = 1'b1; step();
        late_ack = 1'b0; repeat (2) step();

        // Randomized traffic
        fixed_lat = -1;
        for (int c = 0; c < 1500; c++) begin
            pc_valid    = ($urandom_range(0, 1) == 1);
            pAddr       = ($urandom_range(0, 15) == 0) ? $urandom()
                        : ((32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3)));
            flush       = ($urandom_range(0, 9) == 0);
            instr_ready = ($urandom_range(0, 1) == 1);
            step();
        end
        pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b1;
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
